// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz round controller: FSM encodings,
// round result codes and the default per-round time.
package quiz_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_PAUSED = 3'd4;
    localparam logic [2:0] S_JUDGE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_RIGHT   = 2'd1,
        RES_WRONG   = 2'd2,
        RES_TIMEOUT = 2'd3
    } res_e;

    localparam int unsigned DEF_ROUND_TIME = 100;

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Link between the round controller and the shared countdown timer.
interface quiz_round_ctrl_if #(
    parameter int unsigned TIME_W = 7
);
    logic              tmr_load;
    logic [TIME_W-1:0] tmr_value;
    logic              tmr_hold;
    logic [TIME_W-1:0] tmr_time;
    logic              tmr_live;

    modport master (
        output tmr_load, tmr_value, tmr_hold,
        input  tmr_time, tmr_live
    );

    modport slave (
        input  tmr_load, tmr_value, tmr_hold,
        output tmr_time, tmr_live
    );
endinterface

// File: rtl/quiz_score_alu.sv
// Combinational score update: saturating add with time bonus for a right
// answer, floored subtract for a wrong one, no change otherwise.
module quiz_score_alu
    import quiz_pkg::*;
#(
    parameter int unsigned SCORE_W   = 10,
    parameter int unsigned TIME_W    = 7,
    parameter int unsigned PTS_RIGHT = 10,
    parameter int unsigned PTS_WRONG = 5
) (
    input  logic [SCORE_W-1:0] score,
    input  res_e               res,
    input  logic [TIME_W-1:0]  time_s,
    output logic [SCORE_W-1:0] score_next
);

    // Two guard bits above the wider operand so the sum can never wrap.
    localparam int unsigned SW = ((SCORE_W > TIME_W) ? SCORE_W : TIME_W) + 2;
    localparam logic [SW-1:0] MAX_SCORE = {{(SW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    logic [SW-1:0] bonus;
    logic [SW-1:0] sum;

    always_comb begin
        bonus      = SW'(time_s >> 2);
        sum        = SW'(score) + SW'(PTS_RIGHT) + bonus;
        score_next = score;
        case (res)
            RES_RIGHT: score_next = (sum > MAX_SCORE) ? '1 : sum[SCORE_W-1:0];
            RES_WRONG: score_next = (score >= SCORE_W'(PTS_WRONG)) ?
                                    score - SCORE_W'(PTS_WRONG) : '0;
            default:   score_next = score;
        endcase
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Multi-round quiz sequencer: arms the shared countdown timer per round,
// handles pause/abort, scores answers and declares game over.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int unsigned ROUNDS     = 10,
    parameter int unsigned TIME_W     = 7,
    parameter int unsigned ROUND_TIME = DEF_ROUND_TIME,
    parameter int unsigned SCORE_W    = 10,
    parameter int unsigned PTS_RIGHT  = 10,
    parameter int unsigned PTS_WRONG  = 5,
    parameter int unsigned SETTLE     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_p,
    input  logic               abort_p,
    input  logic               pause_p,
    input  logic               ans_valid,
    input  logic               ans_right,
    quiz_round_ctrl_if.master  tmr,
    output logic [3:0]         round_idx,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         last_res,
    output logic               game_over,
    output logic [2:0]         state_o
);

    logic [2:0]         state;
    logic [7:0]         settle_cnt;
    res_e               res;
    logic [TIME_W-1:0]  time_q;
    logic [SCORE_W-1:0] score_next;

    quiz_score_alu #(
        .SCORE_W   (SCORE_W),
        .TIME_W    (TIME_W),
        .PTS_RIGHT (PTS_RIGHT),
        .PTS_WRONG (PTS_WRONG)
    ) u_alu (
        .score      (score),
        .res        (res),
        .time_s     (time_q),
        .score_next (score_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            round_idx  <= '0;
            score      <= '0;
            res        <= RES_NONE;
            time_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_p) begin
                        score     <= '0;
                        round_idx <= 4'd1;
                        res       <= RES_NONE;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (abort_p) begin
                        round_idx <= '0;
                        state     <= S_IDLE;
                    end else if (settle_cnt == 8'(SETTLE - 1)) begin
                        state <= S_PLAY;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                S_PLAY: begin
                    // An answer beats a timer expiry arriving in the same cycle.
                    if (abort_p) begin
                        round_idx <= '0;
                        state     <= S_IDLE;
                    end else if (ans_valid) begin
                        res    <= ans_right ? RES_RIGHT : RES_WRONG;
                        time_q <= tmr.tmr_time;
                        state  <= S_JUDGE;
                    end else if (!tmr.tmr_live) begin
                        res   <= RES_TIMEOUT;
                        state <= S_JUDGE;
                    end else if (pause_p) begin
                        state <= S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (abort_p) begin
                        round_idx <= '0;
                        state     <= S_IDLE;
                    end else if (pause_p) begin
                        state <= S_PLAY;
                    end
                end
                S_JUDGE: begin
                    score <= score_next;
                    if (round_idx == 4'(ROUNDS)) begin
                        state <= S_DONE;
                    end else begin
                        round_idx <= round_idx + 4'd1;
                        state     <= S_LOAD;
                    end
                end
                S_DONE: begin
                    if (start_p) begin
                        score     <= '0;
                        round_idx <= 4'd1;
                        res       <= RES_NONE;
                        state     <= S_LOAD;
                    end else if (abort_p) begin
                        round_idx <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign tmr.tmr_load  = (state == S_LOAD);
    assign tmr.tmr_value = TIME_W'(ROUND_TIME);
    assign tmr.tmr_hold  = (state == S_PAUSED);
    assign last_res      = res;
    assign game_over     = (state == S_DONE);
    assign state_o       = state;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with a 3-round game configuration.
module tb_quiz_round_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_p = 1'b0;
    logic       abort_p = 1'b0;
    logic       pause_p = 1'b0;
    logic       ans_valid = 1'b0;
    logic       ans_right = 1'b0;
    logic [3:0] round_idx;
    logic [9:0] score;
    logic [1:0] last_res;
    logic       game_over;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    quiz_round_ctrl_if #(.TIME_W(7)) tmr_if ();

    quiz_round_ctrl #(
        .ROUNDS     (3),
        .TIME_W     (7),
        .ROUND_TIME (100),
        .SCORE_W    (10),
        .PTS_RIGHT  (10),
        .PTS_WRONG  (5),
        .SETTLE     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_p   (start_p),
        .abort_p   (abort_p),
        .pause_p   (pause_p),
        .ans_valid (ans_valid),
        .ans_right (ans_right),
        .tmr       (tmr_if),
        .round_idx (round_idx),
        .score     (score),
        .last_res  (last_res),
        .game_over (game_over),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_play();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        tmr_if.tmr_time = 7'd0;
        tmr_if.tmr_live = 1'b1;
        #2;
        n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        n_cmp++; if (tmr_if.tmr_value !== 7'd100) begin n_bad++; $display("FAIL reset_tmr_value: got %0d expected 100", tmr_if.tmr_value); end
        n_cmp++; if (tmr_if.tmr_load !== 1'b0) begin n_bad++; $display("FAIL reset_tmr_load: got %0d expected 0", tmr_if.tmr_load); end
        n_cmp++; if (score !== 10'd0) begin n_bad++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_cmp++; if (round_idx !== 4'd0) begin n_bad++; $display("FAIL reset_round: got %0d expected 0", round_idx); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_start();
        start_p = 1'b1; tick(); start_p = 1'b0;
        n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL start_state_load: got %0d expected 1", state_o); end
        n_cmp++; if (tmr_if.tmr_load !== 1'b1) begin n_bad++; $display("FAIL start_tmr_load: got %0d expected 1", tmr_if.tmr_load); end
        n_cmp++; if (round_idx !== 4'd1) begin n_bad++; $display("FAIL start_round: got %0d expected 1", round_idx); end
        tick();
        n_cmp++; if (tmr_if.tmr_load !== 1'b0) begin n_bad++; $display("FAIL start_load_one_cycle: got %0d expected 0", tmr_if.tmr_load); end
        n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL start_state_settle: got %0d expected 2", state_o); end
        tick(); tick();
        n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL start_state_play: got %0d expected 3", state_o); end
    endtask

    task automatic test_right();
        tmr_if.tmr_time = 7'd40;
        ans_valid = 1'b1; ans_right = 1'b1; tick(); ans_valid = 1'b0;
        n_cmp++; if (state_o !== 3'd5) begin n_bad++; $display("FAIL right_state_judge: got %0d expected 5", state_o); end
        n_cmp++; if (last_res !== 2'd1) begin n_bad++; $display("FAIL right_last_res: got %0d expected 1", last_res); end
        tick();
        n_cmp++; if (score !== 10'd20) begin n_bad++; $display("FAIL right_score: got %0d expected 20", score); end
        n_cmp++; if (round_idx !== 4'd2) begin n_bad++; $display("FAIL right_round: got %0d expected 2", round_idx); end
        n_cmp++; if (tmr_if.tmr_load !== 1'b1) begin n_bad++; $display("FAIL right_next_load: got %0d expected 1", tmr_if.tmr_load); end
        go_play();
    endtask

    task automatic test_wrong();
        tmr_if.tmr_time = 7'd60;
        ans_valid = 1'b1; ans_right = 1'b0; tick(); ans_valid = 1'b0;
        n_cmp++; if (last_res !== 2'd2) begin n_bad++; $display("FAIL wrong_last_res: got %0d expected 2", last_res); end
        tick();
        n_cmp++; if (score !== 10'd15) begin n_bad++; $display("FAIL wrong_score: got %0d expected 15", score); end
        n_cmp++; if (round_idx !== 4'd3) begin n_bad++; $display("FAIL wrong_round: got %0d expected 3", round_idx); end
        go_play();
    endtask

    task automatic test_pause_and_race();
        pause_p = 1'b1; tick(); pause_p = 1'b0;
        n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL pause_state: got %0d expected 4", state_o); end
        n_cmp++; if (tmr_if.tmr_hold !== 1'b1) begin n_bad++; $display("FAIL pause_hold: got %0d expected 1", tmr_if.tmr_hold); end
        ans_valid = 1'b1; ans_right = 1'b1; tick(); ans_valid = 1'b0;
        n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL pause_ans_ignored_state: got %0d expected 4", state_o); end
        n_cmp++; if (last_res !== 2'd2) begin n_bad++; $display("FAIL pause_ans_ignored_res: got %0d expected 2", last_res); end
        pause_p = 1'b1; tick(); pause_p = 1'b0;
        n_cmp++; if (tmr_if.tmr_hold !== 1'b0) begin n_bad++; $display("FAIL resume_hold: got %0d expected 0", tmr_if.tmr_hold); end
        n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL resume_state: got %0d expected 3", state_o); end
        tmr_if.tmr_time = 7'd0; tmr_if.tmr_live = 1'b0;
        ans_valid = 1'b1; ans_right = 1'b1; tick(); ans_valid = 1'b0;
        tmr_if.tmr_live = 1'b1;
        n_cmp++; if (last_res !== 2'd1) begin n_bad++; $display("FAIL race_last_res: got %0d expected 1", last_res); end
        tick();
        n_cmp++; if (score !== 10'd25) begin n_bad++; $display("FAIL race_score: got %0d expected 25", score); end
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL done_game_over: got %0d expected 1", game_over); end
        n_cmp++; if (state_o !== 3'd6) begin n_bad++; $display("FAIL done_state: got %0d expected 6", state_o); end
        n_cmp++; if (tmr_if.tmr_load !== 1'b0) begin n_bad++; $display("FAIL done_no_load: got %0d expected 0", tmr_if.tmr_load); end
        pause_p = 1'b1; tick(); pause_p = 1'b0;
        n_cmp++; if (state_o !== 3'd6) begin n_bad++; $display("FAIL done_pause_ignored: got %0d expected 6", state_o); end
        n_cmp++; if (score !== 10'd25) begin n_bad++; $display("FAIL done_score_held: got %0d expected 25", score); end
    endtask

    task automatic test_restart_floor();
        start_p = 1'b1; tick(); start_p = 1'b0;
        n_cmp++; if (score !== 10'd0) begin n_bad++; $display("FAIL restart_score: got %0d expected 0", score); end
        n_cmp++; if (round_idx !== 4'd1) begin n_bad++; $display("FAIL restart_round: got %0d expected 1", round_idx); end
        tick();
        ans_valid = 1'b1; ans_right = 1'b1; tick(); ans_valid = 1'b0;
        tick();
        n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL settle_ans_ignored: got %0d expected 3", state_o); end
        tmr_if.tmr_time = 7'd50;
        ans_valid = 1'b1; ans_right = 1'b0; tick(); ans_valid = 1'b0;
        tick();
        n_cmp++; if (score !== 10'd0) begin n_bad++; $display("FAIL wrong_floor: got %0d expected 0", score); end
        go_play();
        tmr_if.tmr_time = 7'd12;
        ans_valid = 1'b1; ans_right = 1'b1; tick(); ans_valid = 1'b0;
        tick();
        n_cmp++; if (score !== 10'd13) begin n_bad++; $display("FAIL right_bonus12: got %0d expected 13", score); end
        go_play();
        tmr_if.tmr_live = 1'b0; tick(); tmr_if.tmr_live = 1'b1;
        n_cmp++; if (last_res !== 2'd3) begin n_bad++; $display("FAIL timeout_last_res: got %0d expected 3", last_res); end
        tick();
        n_cmp++; if (score !== 10'd13) begin n_bad++; $display("FAIL timeout_score: got %0d expected 13", score); end
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL game2_over: got %0d expected 1", game_over); end
    endtask

    task automatic test_abort_done();
        abort_p = 1'b1; tick(); abort_p = 1'b0;
        n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL abort_done_state: got %0d expected 0", state_o); end
        n_cmp++; if (score !== 10'd13) begin n_bad++; $display("FAIL abort_done_score_kept: got %0d expected 13", score); end
        n_cmp++; if (round_idx !== 4'd0) begin n_bad++; $display("FAIL abort_done_round: got %0d expected 0", round_idx); end
    endtask

    task automatic test_abort_paused();
        start_p = 1'b1; tick(); start_p = 1'b0;
        go_play();
        pause_p = 1'b1; tick(); pause_p = 1'b0;
        abort_p = 1'b1; tick(); abort_p = 1'b0;
        n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL abort_paused_state: got %0d expected 0", state_o); end
        n_cmp++; if (tmr_if.tmr_hold !== 1'b0) begin n_bad++; $display("FAIL abort_paused_hold: got %0d expected 0", tmr_if.tmr_hold); end
        n_cmp++; if (tmr_if.tmr_load !== 1'b0) begin n_bad++; $display("FAIL abort_paused_load: got %0d expected 0", tmr_if.tmr_load); end
        n_cmp++; if (round_idx !== 4'd0) begin n_bad++; $display("FAIL abort_paused_round: got %0d expected 0", round_idx); end
    endtask

    task automatic test_async_reset();
        start_p = 1'b1; tick(); start_p = 1'b0;
        tmr_if.tmr_live = 1'b0;
        for (int i = 0; i < 50 && state_o !== 3'd6; i++) tick();
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL timeout_game_over: got %0d expected 1", game_over); end
        n_cmp++; if (last_res !== 2'd3) begin n_bad++; $display("FAIL timeout_game_res: got %0d expected 3", last_res); end
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL areset_state: got %0d expected 0", state_o); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL areset_game_over: got %0d expected 0", game_over); end
        n_cmp++; if (round_idx !== 4'd0) begin n_bad++; $display("FAIL areset_round: got %0d expected 0", round_idx); end
        n_cmp++; if (last_res !== 2'd0) begin n_bad++; $display("FAIL areset_last_res: got %0d expected 0", last_res); end
        n_cmp++; if (tmr_if.tmr_hold !== 1'b0) begin n_bad++; $display("FAIL areset_hold: got %0d expected 0", tmr_if.tmr_hold); end
        n_cmp++; if (tmr_if.tmr_value !== 7'd100) begin n_bad++; $display("FAIL areset_tmr_value: got %0d expected 100", tmr_if.tmr_value); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_right();
        test_wrong();
        test_pause_and_race();
        test_restart_floor();
        test_abort_done();
        test_abort_paused();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
- Sequences a multi-round quiz game around the shared 1 Hz countdown timer.
- Arms the timer at the start of each round and holds it while paused.
- Accepts answer submissions and scores them with a time bonus; counts rounds and declares game over.
- Sits between the input-conditioning logic (debounced single-cycle pulses) and the timer/display datapath.

Parameters:
- ROUNDS, 10, rounds per game (1..15)
- TIME_W, 7, width of timer value
- ROUND_TIME, 100, seconds loaded into timer per round
- SCORE_W, 10, score register width
- PTS_RIGHT, 10, base points for a correct answer
- PTS_WRONG, 5, penalty for a wrong answer
- SETTLE, 2, cycles after timer load before timer_live is trusted

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start_p  in  1  single-cycle start/restart pulse
- abort_p  in  1  single-cycle abort pulse, returns to IDLE
- pause_p  in  1  single-cycle pause/resume toggle
- ans_valid  in  1  single-cycle answer submission
- ans_right  in  1  answer correctness, qualified by ans_valid
- tmr_time  in  TIME_W  remaining seconds from timer
- tmr_live  in  1  timer still running (1) / expired (0)
- tmr_load  out  1  single-cycle pulse: load and restart timer
- tmr_value  out  TIME_W  value to load, constant ROUND_TIME
- tmr_hold  out  1  freeze timer while 1
- round_idx  out  4  current round, 1-based; 0 in IDLE
- score  out  SCORE_W  accumulated score
- last_res  out  2  result of last round: 0 none, 1 right, 2 wrong, 3 timeout
- game_over  out  1  high in DONE
- state_o  out  3  encoded FSM state, for display

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except tmr_value=ROUND_TIME.
- States: IDLE, LOAD, SETTLE, PLAY, PAUSED, JUDGE, DONE.
- IDLE: on start_p: score=0, round_idx=1 -> LOAD.
- LOAD: tmr_load=1 for exactly this cycle -> SETTLE.
- SETTLE: count SETTLE cycles; ignore all inputs except abort_p -> PLAY.
- PLAY, priority order:
  - abort_p -> IDLE.
  - ans_valid -> latch result -> JUDGE. Answer wins over a same-cycle tmr_live fall.
  - tmr_live=0 -> last_res=3 -> JUDGE.
  - pause_p -> PAUSED.
- PAUSED: tmr_hold=1; ans_valid is ignored.
  - pause_p -> PLAY (tmr_hold drops the same edge).
  - abort_p -> IDLE.
- JUDGE: one cycle; score updates on exit.
  - Right answer: score += PTS_RIGHT + (tmr_time>>2), with tmr_time sampled in the answer cycle; saturates at 2^SCORE_W-1.
  - Wrong answer: score -= PTS_WRONG, floor 0.
  - Timeout: score unchanged.
  - Exit: if round_idx==ROUNDS -> DONE; else round_idx+1 -> LOAD.
- DONE: game_over=1; score and last_res held.
  - start_p -> clear score, round_idx=1 -> LOAD.
  - abort_p -> IDLE with score retained.
- start_p is ignored in all states except IDLE and DONE. pause_p is ignored outside PLAY/PAUSED.
- All arithmetic is unsigned. The bonus path is zero-extended to SCORE_W before the add.
- Back-to-back rounds: JUDGE->LOAD gives a 1-cycle gap, so tmr_load pulses are never adjacent.
- Abort or reset mid-round: tmr_hold=0 and no tmr_load issued. The timer keeps its value until the next LOAD.

Decomposition:
- Shared package (quiz_pkg): state enum, last_res codes (RES_NONE/RIGHT/WRONG/TIMEOUT), default ROUND_TIME.
- One sub-module: quiz_score_alu. It is combinational and computes the saturating add/sub plus bonus from the current score, result code and sampled time.
- FSM and counters stay in quiz_round_ctrl.

Test Plan:
- Reset then start_p -> tmr_load high for exactly 1 cycle, round_idx=1, state PLAY after SETTLE+1 cycles.
- In PLAY with tmr_time=40, ans_valid, ans_right=1 -> score 0->20 (10+40>>2), last_res=1, next tmr_load 2 cycles later, round_idx=2.
- Wrong answer with score=3 -> score=0 (floor), last_res=2. Then tmr_live=0 in next round -> last_res=3, score unchanged.
- ans_valid in the same cycle tmr_live falls, with tmr_time=0 and ans_right=1 -> scored as right, score +10.
- pause_p in PLAY -> tmr_hold=1, ans_valid ignored. pause_p again -> tmr_hold=0, then an answer is accepted.
- ROUNDS=3 full game -> game_over=1 after round 3 JUDGE. Assert rst low mid-DONE -> all outputs 0 asynchronously. abort_p during PAUSED -> IDLE, tmr_hold=0.
